// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clk down to a pixel tick and produces HC/VC/FC counters,
// active-low syncs, a visible-window flag and pixel/frame strobes, all registered.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned H_PULSE = 96,
  parameter int unsigned V_PULSE = 2,
  parameter int unsigned LEDGE   = 144,
  parameter int unsigned REDGE   = 784,
  parameter int unsigned UEDGE   = 35,
  parameter int unsigned DEDGE   = 515,
  parameter int unsigned FC_MAX  = 49
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] HC,
  output logic [9:0] VC,
  output logic [5:0] FC,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_tick,
  output logic       video_on
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HMax   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VMax   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HPulse = 10'(H_PULSE);
  localparam logic [9:0]      VPulse = 10'(V_PULSE);
  localparam logic [9:0]      LEdge  = 10'(LEDGE);
  localparam logic [9:0]      REdge  = 10'(REDGE);
  localparam logic [9:0]      UEdge  = 10'(UEDGE);
  localparam logic [9:0]      DEdge  = 10'(DEDGE);
  localparam logic [5:0]      FcMax  = 6'(FC_MAX);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : gen_chk_div
    $error("CLK_DIV must be in 1..16");
  end
  if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 1024) begin : gen_chk_total
    $error("H_TOTAL and V_TOTAL must be in 1..1024");
  end
  if (FC_MAX > 63) begin : gen_chk_fc
    $error("FC_MAX must be at most 63");
  end

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hc_d, vc_d;
  logic [5:0]      fc_d;
  logic            tick_d, frame_d, hsync_d, vsync_d, video_d;

  always_comb begin
    div_d  = (div_q == DivMax) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DivMax);
    hc_d   = HC;
    vc_d   = VC;
    fc_d   = FC;
    if (pix_tick) begin
      if (HC == HMax) begin
        hc_d = '0;
        if (VC == VMax) begin
          vc_d = '0;
          fc_d = (FC == FcMax) ? '0 : FC + 1'b1;
        end else begin
          vc_d = VC + 1'b1;
        end
      end else begin
        hc_d = HC + 1'b1;
      end
    end
    // Decoded from the next coordinates so they land on the outputs together with HC/VC.
    frame_d = tick_d && (hc_d == HMax) && (vc_d == VMax);
    hsync_d = ~(hc_d < HPulse);
    vsync_d = ~(vc_d < VPulse);
    video_d = (hc_d > LEdge) && (hc_d <= REdge) && (vc_d > UEdge) && (vc_d <= DEdge);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      HC         <= '0;
      VC         <= '0;
      FC         <= '0;
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      video_on   <= 1'b0;
    end else begin
      div_q      <= div_d;
      HC         <= hc_d;
      VC         <= vc_d;
      FC         <= fc_d;
      pix_tick   <= tick_d;
      frame_tick <= frame_d;
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      video_on   <= video_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line timing, a small-geometry instance for frame/FC/window
// behaviour and mid-frame reset, and a CLK_DIV=1 instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [9:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic [5:0] a_fc, b_fc, c_fc;
  logic       a_hs, a_vs, a_pt, a_ft, a_vo;
  logic       b_hs, b_vs, b_pt, b_ft, b_vo;
  logic       c_hs, c_vs, c_pt, c_ft, c_vo;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .HC(a_hc), .VC(a_vc), .FC(a_fc), .hsync(a_hs), .vsync(a_vs),
    .pix_tick(a_pt), .frame_tick(a_ft), .video_on(a_vo)
  );

  // Small frame: 16x12 pixels, visible HC 5..12, VC 3..9, FC period 6.
  vga_timing_gen #(
    .CLK_DIV(3), .H_TOTAL(16), .V_TOTAL(12), .H_PULSE(3), .V_PULSE(2),
    .LEDGE(4), .REDGE(12), .UEDGE(2), .DEDGE(9), .FC_MAX(5)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .HC(b_hc), .VC(b_vc), .FC(b_fc), .hsync(b_hs), .vsync(b_vs),
    .pix_tick(b_pt), .frame_tick(b_ft), .video_on(b_vo)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(16), .V_TOTAL(12), .H_PULSE(3), .V_PULSE(2),
    .LEDGE(4), .REDGE(12), .UEDGE(2), .DEDGE(9), .FC_MAX(5)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .HC(c_hc), .VC(c_vc), .FC(c_fc), .hsync(c_hs), .vsync(c_vs),
    .pix_tick(c_pt), .frame_tick(c_ft), .video_on(c_vo)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int lo, bad, wrap_c, prev_hc, prev_vc;
    int nft, first_ft, last_ft, per, ftbad, prev_ft, pending, frames, fc_exp, fclow;
    int vlo, vis, vbad, vobad, p_a, p_b, p_c, p_d, p_e, found;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("rst_hc", a_hc, 0);
    check("rst_vc", a_vc, 0);
    check("rst_fc", a_fc, 0);
    check("rst_hsync", a_hs, 0);
    check("rst_vsync", a_vs, 0);
    check("rst_pix_tick", a_pt, 0);
    check("rst_frame_tick", a_ft, 0);
    check("rst_video_on", a_vo, 0);

    // Default geometry: first tick and one full line
    rst_a   = 1'b0;
    lo      = 0;
    bad     = 0;
    wrap_c  = 0;
    prev_hc = -1;
    prev_vc = -1;
    for (int k = 1; k <= 3300; k++) begin
      if (k <= 5) begin
        check($sformatf("a_tick_clk%0d", k), a_pt, int'(k == 4));
        check($sformatf("a_hc_clk%0d", k), a_hc, int'(k == 5));
      end
      if (a_vc == 0 && !a_hs) lo++;
      if (a_hs != (a_hc >= 96)) bad++;
      if (a_vc == 1) begin
        wrap_c = k;
        break;
      end
      prev_hc = a_hc;
      prev_vc = a_vc;
      @(negedge clk);
    end
    check("a_wrap_clk", wrap_c, 3201);
    check("a_wrap_hc", a_hc, 0);
    check("a_wrap_vc", a_vc, 1);
    check("a_prev_hc", prev_hc, 799);
    check("a_prev_vc", prev_vc, 0);
    check("a_hsync_low_clks", lo, 384);
    check("a_hsync_shape", bad, 0);
    rst_a = 1'b1;

    // Small geometry: seven frames from reset
    rst_b    = 1'b0;
    nft      = 0;
    first_ft = 0;
    last_ft  = 0;
    per      = 0;
    ftbad    = 0;
    prev_ft  = 0;
    pending  = 0;
    frames   = 0;
    fc_exp   = 0;
    fclow    = 0;
    vlo      = 0;
    vis      = 0;
    vbad     = 0;
    vobad    = 0;
    p_a = -1; p_b = -1; p_c = -1; p_d = -1; p_e = -1;
    for (int k = 1; k <= 5000; k++) begin
      if (b_ft) begin
        nft++;
        if (nft == 1) first_ft = k;
        else if (nft == 2) per = k - last_ft;
        last_ft = k;
        if (!(b_pt && b_hc == 15 && b_vc == 11) || prev_ft != 0) ftbad++;
        if (nft <= 6 && b_fc < 3) fclow++;
        check($sformatf("b_fc_pre_f%0d", nft), b_fc, fc_exp);
        pending = 1;
      end else if (pending != 0) begin
        fc_exp = (fc_exp + 1) % 6;
        check($sformatf("b_fc_post_f%0d", nft), b_fc, fc_exp);
        check($sformatf("b_hc_post_f%0d", nft), b_hc, 0);
        check($sformatf("b_vc_post_f%0d", nft), b_vc, 0);
        pending = 0;
        frames++;
        if (frames == 7) break;
      end
      if (b_pt && frames == 0) begin
        if (!b_vs) vlo++;
        if (b_vo) vis++;
        if (b_vs != (b_vc >= 2)) vbad++;
        if (b_vo != (b_hc > 4 && b_hc <= 12 && b_vc > 2 && b_vc <= 9)) vobad++;
        if (b_hc == 4 && b_vc == 3) p_a = b_vo;
        if (b_hc == 5 && b_vc == 3) p_b = b_vo;
        if (b_hc == 12 && b_vc == 9) p_c = b_vo;
        if (b_hc == 13 && b_vc == 9) p_d = b_vo;
        if (b_hc == 5 && b_vc == 10) p_e = b_vo;
      end
      prev_ft = b_ft;
      @(negedge clk);
    end
    check("b_frames", frames, 7);
    check("b_first_frame_tick_clk", first_ft, 576);
    check("b_frame_period", per, 576);
    check("b_frame_tick_shape", ftbad, 0);
    check("b_fc_low_frames", fclow, 3);
    check("b_vsync_low_pixels", vlo, 32);
    check("b_vsync_shape", vbad, 0);
    check("b_visible_pixels", vis, 56);
    check("b_video_shape", vobad, 0);
    check("b_vo_4_3", p_a, 0);
    check("b_vo_5_3", p_b, 1);
    check("b_vo_12_9", p_c, 1);
    check("b_vo_13_9", p_d, 0);
    check("b_vo_5_10", p_e, 0);

    // Mid-frame reset
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      if (b_hc == 8 && b_vc == 6) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("b_reached_8_6", found, 1);
    check("b_fc_before_rst", b_fc, 1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_mid_rst_hc", b_hc, 0);
    check("b_mid_rst_vc", b_vc, 0);
    check("b_mid_rst_fc", b_fc, 0);
    check("b_mid_rst_hsync", b_hs, 0);
    check("b_mid_rst_vsync", b_vs, 0);
    check("b_mid_rst_pix_tick", b_pt, 0);
    check("b_mid_rst_frame_tick", b_ft, 0);
    check("b_mid_rst_video_on", b_vo, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        check($sformatf("b_restart_tick_clk%0d", k), b_pt, int'(k == 3));
        check($sformatf("b_restart_hc_clk%0d", k), b_hc, int'(k == 4));
      end
      if (k < 4) @(negedge clk);
    end

    // CLK_DIV=1: tick every clk once out of reset
    rst_c = 1'b0;
    bad   = 0;
    for (int k = 1; k <= 12; k++) begin
      if (c_pt != (k >= 2)) bad++;
      if (c_hc != ((k <= 2) ? 0 : k - 2)) bad++;
      @(negedge clk);
    end
    check("c_div1_tick_and_hc", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
